// File: rtl/mem_rr_arbiter_if.sv
// Bundle of client-side and memory-side signals for mem_rr_arbiter.
// The arbiter owns the "master" modport (it is the master of the memory port
// and the responder to the clients); the surrounding system uses "slave".
interface mem_rr_arbiter_if #(
    parameter int CLIENTS = 4,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 16
);
    localparam int IDXW = $clog2(CLIENTS);

    // Client side
    logic [CLIENTS-1:0]       cl_request;
    logic [CLIENTS-1:0]       cl_write;
    logic [CLIENTS*ADDRW-1:0] cl_addr;
    logic [CLIENTS*DATAW-1:0] cl_wdata;
    logic [CLIENTS-1:0]       cl_done;
    logic [DATAW-1:0]         cl_rdata;
    logic                     cl_error;
    logic [IDXW-1:0]          grant_idx;

    // Memory side
    logic                     mem_wr_enable;
    logic [ADDRW-1:0]         mem_wr_addr;
    logic [DATAW-1:0]         mem_wr_data;
    logic                     mem_rd_enable;
    logic [ADDRW-1:0]         mem_rd_addr;
    logic [DATAW-1:0]         mem_rd_data;
    logic                     mem_rd_ready;
    logic                     mem_busy;

    modport master (
        input  cl_request, cl_write, cl_addr, cl_wdata,
        input  mem_rd_data, mem_rd_ready, mem_busy,
        output cl_done, cl_rdata, cl_error, grant_idx,
        output mem_wr_enable, mem_wr_addr, mem_wr_data,
        output mem_rd_enable, mem_rd_addr
    );

    modport slave (
        output cl_request, cl_write, cl_addr, cl_wdata,
        output mem_rd_data, mem_rd_ready, mem_busy,
        input  cl_done, cl_rdata, cl_error, grant_idx,
        input  mem_wr_enable, mem_wr_addr, mem_wr_data,
        input  mem_rd_enable, mem_rd_addr
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// N-client round-robin arbiter onto a single-word memory port.
// One transaction in flight at a time: grant, strobe (held off by mem_busy),
// optional read wait with timeout, then a one-cycle cl_done to the winner.
module mem_rr_arbiter #(
    parameter int CLIENTS    = 4,
    parameter int ADDRW      = 16,
    parameter int DATAW      = 16,
    parameter int RD_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               nRst,
    mem_rr_arbiter_if.master   bus
);
    localparam int          IDXW     = $clog2(CLIENTS);
    localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q;        // last served client
    logic [IDXW-1:0]   idx_q;        // client owning the current transaction
    logic              op_write_q;
    logic [ADDRW-1:0]  addr_q;
    logic [DATAW-1:0]  wdata_q;
    logic [DATAW-1:0]  rdata_q;
    logic              err_q;
    logic [15:0]       cnt_q;

    logic              pick_valid;
    logic [IDXW-1:0]   pick_idx;
    logic [IDXW-1:0]   cand;
    logic              sel_write;
    logic [ADDRW-1:0]  sel_addr;
    logic [DATAW-1:0]  sel_wdata;
    logic              strobe;
    logic              rd_timeout;

    // Round-robin scan: first requester after the last served client.
    // NOTE: every variable written in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= CLIENTS; i++) begin
            cand = IDXW'((int'(ptr_q) + i) % CLIENTS);
            if (!pick_valid && bus.cl_request[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the winning client's op, address and write data for latching.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (pick_idx == IDXW'(i)) begin
                sel_write = bus.cl_write[i];
                sel_addr  = bus.cl_addr[i*ADDRW +: ADDRW];
                sel_wdata = bus.cl_wdata[i*DATAW +: DATAW];
            end
        end
    end

    assign strobe     = (state_q == ISSUE) && !bus.mem_busy;
    assign rd_timeout = (state_q == WAIT_RD) && !bus.mem_rd_ready && (cnt_q == TMO_LAST);

    // Next-state logic and combinational outputs of the transaction FSM.
    always_comb begin
        state_d           = state_q;
        bus.mem_wr_enable = 1'b0;
        bus.mem_rd_enable = 1'b0;
        bus.cl_done       = '0;
        bus.cl_error      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) state_d = ISSUE;
            end
            ISSUE: begin
                bus.mem_wr_enable = strobe && op_write_q;
                bus.mem_rd_enable = strobe && !op_write_q;
                if (strobe) state_d = op_write_q ? DONE : WAIT_RD;
            end
            WAIT_RD: begin
                if (bus.mem_rd_ready || rd_timeout) state_d = DONE;
            end
            DONE: begin
                bus.cl_done[idx_q] = 1'b1;
                bus.cl_error       = err_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Grant latching, timeout counting and read-data capture.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ptr_q      <= IDXW'(CLIENTS - 1);
            idx_q      <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        idx_q      <= pick_idx;
                        ptr_q      <= pick_idx;
                        op_write_q <= sel_write;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                    end
                end
                ISSUE: begin
                    if (strobe) cnt_q <= '0;
                end
                WAIT_RD: begin
                    if (bus.mem_rd_ready) begin
                        rdata_q <= bus.mem_rd_data;
                    end else if (rd_timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Buses come from the latched transaction in every state.
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = wdata_q;
    assign bus.mem_rd_addr = addr_q;
    assign bus.cl_rdata    = rdata_q;
    assign bus.grant_idx   = idx_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: stimulus pushes expected transactions
// in predicted service order; a monitor checks strobes and completions.
module tb_mem_rr_arbiter;
    localparam int CLIENTS    = 4;
    localparam int ADDRW      = 16;
    localparam int DATAW      = 16;
    localparam int RD_TIMEOUT = 8;
    localparam int MAXC       = 4;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [15:0] data;
        logic        never;
        logic        stray;
        logic [7:0]  delay;
    } txn_t;

    typedef struct packed {
        logic [1:0]  idx;
        logic        write;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic nRst;

    mem_rr_arbiter_if #(.CLIENTS(CLIENTS), .ADDRW(ADDRW), .DATAW(DATAW)) bus ();

    mem_rr_arbiter #(
        .CLIENTS(CLIENTS), .ADDRW(ADDRW), .DATAW(DATAW), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    txn_t        plan_q[$];
    logic [15:0] mem_exp [256];
    logic [15:0] ram [256];
    int          rr_last = CLIENTS - 1;
    bit          busy_rand = 0;
    int          busy_until = -1;
    int          cyc = 0;
    bit          strobed;
    txn_t        cq [CLIENTS][MAXC];
    int          cnt_b [CLIENTS];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic txn_t gen_txn();
        txn_t t;
        t.write = 1'($urandom_range(0, 1));
        t.addr  = 16'($urandom_range(0, 15));
        t.data  = 16'($urandom);
        t.never = ($urandom_range(0, 9) == 0);
        t.stray = ($urandom_range(0, 3) == 0);
        t.delay = 8'($urandom_range(1, RD_TIMEOUT - 2));
        return t;
    endfunction

    // Reference model: service order is decided elsewhere; this applies the
    // transaction to the model memory and records what the client must see.
    task automatic model_push(input int c, input txn_t t);
        exp_t e;
        e.idx   = 2'(c);
        e.write = t.write;
        e.addr  = t.addr;
        e.data  = t.data;
        e.rdata = '0;
        e.err   = 1'b0;
        if (t.write) begin
            mem_exp[t.addr[7:0]] = t.data;
        end else begin
            if (t.never) e.err = 1'b1;
            else         e.rdata = mem_exp[t.addr[7:0]];
            plan_q.push_back(t);
        end
        exp_q.push_back(e);
    endtask

    task automatic raise(input int c, input txn_t t);
        bus.cl_write[c]                = t.write;
        bus.cl_addr[c*ADDRW +: ADDRW]  = t.addr;
        bus.cl_wdata[c*DATAW +: DATAW] = t.data;
        bus.cl_request[c]              = 1'b1;
    endtask

    task automatic wait_done(input int c, output int cycles);
        bit seen;
        seen   = 0;
        cycles = 0;
        while (!seen && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (bus.cl_done[c]) begin
                seen = 1;
                bus.cl_request[c] = 1'b0;
            end
        end
        if (!seen) check("done_seen", 32'(bus.cl_done[c]), 1);
    endtask

    // Random batch: per-client transaction counts in cnt_b; order predicted by
    // serving whoever is next after the last served client with work left.
    task automatic run_batch();
        int rem[CLIENTS];
        int pos[CLIENTS];
        bit just_done[CLIENTS];
        int total, outstanding, cycles, pick;
        total = 0;
        for (int i = 0; i < CLIENTS; i++) begin
            rem[i] = cnt_b[i];
            pos[i] = 0;
            just_done[i] = 0;
            total += cnt_b[i];
            for (int k = 0; k < cnt_b[i]; k++) cq[i][k] = gen_txn();
        end
        for (int n = 0; n < total; n++) begin
            pick = -1;
            for (int j = 1; j <= CLIENTS; j++) begin
                int c;
                c = (rr_last + j) % CLIENTS;
                if (pick < 0 && rem[c] > 0) pick = c;
            end
            model_push(pick, cq[pick][cnt_b[pick] - rem[pick]]);
            rem[pick]--;
            rr_last = pick;
        end
        @(negedge clk);
        for (int i = 0; i < CLIENTS; i++) begin
            if (cnt_b[i] > 0) begin
                raise(i, cq[i][0]);
                pos[i] = 1;
            end
        end
        outstanding = total;
        cycles = 0;
        while (outstanding > 0 && cycles < 40 * total + 50) begin
            @(negedge clk);
            cycles++;
            for (int i = 0; i < CLIENTS; i++) begin
                if (bus.cl_request[i] && bus.cl_done[i]) begin
                    bus.cl_request[i] = 1'b0;
                    just_done[i] = 1;
                    outstanding--;
                end else if (just_done[i]) begin
                    just_done[i] = 0;
                    if (pos[i] < cnt_b[i]) begin
                        raise(i, cq[i][pos[i]]);
                        pos[i]++;
                    end
                end
            end
        end
        check("batch_complete", 32'(outstanding), 0);
    endtask

    // Memory busy driver: forced window or random back-pressure.
    initial begin
        bus.mem_busy = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (cyc <= busy_until) bus.mem_busy = 1'b1;
            else                   bus.mem_busy = busy_rand && ($urandom_range(0, 3) == 0);
        end
    end

    // Memory responder: answers each read strobe per its plan, injects stray
    // ready pulses whenever no read is legitimately outstanding.
    initial begin
        int          left;
        logic [7:0]  paddr;
        bit          waiting, never_wait, drove;
        txn_t        p;
        for (int a = 0; a < 256; a++) ram[a] = 16'(a) ^ 16'h5A5A;
        ram[8'h42] = 16'h1234;
        bus.mem_rd_ready = 1'b0;
        bus.mem_rd_data  = '0;
        waiting = 0; never_wait = 0; left = 0; paddr = '0;
        forever begin
            @(negedge clk);
            bus.mem_rd_ready = 1'b0;
            bus.mem_rd_data  = '0;
            drove = 0;
            if (!nRst) begin
                waiting = 0;
                never_wait = 0;
            end else begin
                if (bus.mem_wr_enable) ram[bus.mem_wr_addr[7:0]] = bus.mem_wr_data;
                if (waiting) begin
                    left--;
                    if (left == 0) begin
                        bus.mem_rd_ready = 1'b1;
                        bus.mem_rd_data  = ram[paddr];
                        waiting = 0;
                        drove = 1;
                    end
                end
                if (never_wait && bus.cl_done != '0) never_wait = 0;
                if (bus.mem_rd_enable) begin
                    check("rd_strobe_planned", 32'(plan_q.size() > 0), 1);
                    if (plan_q.size() > 0) begin
                        p = plan_q.pop_front();
                        paddr = bus.mem_rd_addr[7:0];
                        if (p.never) never_wait = 1;
                        else begin
                            waiting = 1;
                            left = int'(p.delay);
                        end
                        if (p.stray) begin
                            bus.mem_rd_ready = 1'b1;
                            bus.mem_rd_data  = 16'hDEAD;
                        end
                    end
                end else if (!waiting && !never_wait && !drove && $urandom_range(0, 7) == 0) begin
                    bus.mem_rd_ready = 1'b1;
                    bus.mem_rd_data  = 16'hBAD0;
                end
            end
        end
    end

    // Monitor: compares every strobe and completion against the scoreboard.
    initial begin
        exp_t e;
        strobed = 0;
        forever begin
            @(negedge clk);
            if (!nRst) begin
                strobed = 0;
            end else begin
                if (bus.mem_wr_enable || bus.mem_rd_enable) begin
                    check("strobe_exclusive", 32'(bus.mem_wr_enable & bus.mem_rd_enable), 0);
                    check("strobe_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        check("strobe_once", 32'(strobed), 0);
                        strobed = 1;
                        check("strobe_op", 32'(bus.mem_wr_enable), 32'(e.write));
                        if (e.write) begin
                            check("wr_addr", 32'(bus.mem_wr_addr), 32'(e.addr));
                            check("wr_data", 32'(bus.mem_wr_data), 32'(e.data));
                        end else begin
                            check("rd_addr", 32'(bus.mem_rd_addr), 32'(e.addr));
                        end
                    end
                end
                if (bus.cl_done != '0) begin
                    check("done_onehot", 32'($onehot(bus.cl_done)), 1);
                    check("done_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("done_client", 32'(bus.cl_done), 32'(1) << e.idx);
                        check("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
                        check("cl_error", 32'(bus.cl_error), 32'(e.err));
                        if (!e.write) check("cl_rdata", 32'(bus.cl_rdata), 32'(e.rdata));
                        check("done_after_strobe", 32'(strobed), 1);
                        strobed = 0;
                    end
                end else if (bus.cl_error) begin
                    check("error_without_done", 32'(bus.cl_error), 0);
                end
            end
        end
    end

    initial begin
        txn_t t;
        int   cycles;
        int   c0;
        bit   hit;
        for (int a = 0; a < 256; a++) mem_exp[a] = 16'(a) ^ 16'h5A5A;
        mem_exp[8'h42] = 16'h1234;
        bus.cl_request = '0;
        bus.cl_write   = '0;
        bus.cl_addr    = '0;
        bus.cl_wdata   = '0;
        nRst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_done",     32'(bus.cl_done), 0);
        check("rst_error",    32'(bus.cl_error), 0);
        check("rst_wr_en",    32'(bus.mem_wr_enable), 0);
        check("rst_rd_en",    32'(bus.mem_rd_enable), 0);
        check("rst_rdata",    32'(bus.cl_rdata), 0);
        check("rst_grant",    32'(bus.grant_idx), 0);
        check("rst_wr_addr",  32'(bus.mem_wr_addr), 0);
        check("rst_wr_data",  32'(bus.mem_wr_data), 0);
        check("rst_rd_addr",  32'(bus.mem_rd_addr), 0);
        nRst = 1'b1;
        @(negedge clk);

        // Single write from client 2: strobe in cycle 1, done in cycle 2
        t = '0;
        t.write = 1'b1; t.addr = 16'h0010; t.data = 16'hBEEF;
        model_push(2, t); rr_last = 2;
        raise(2, t);
        @(negedge clk);
        check("wr_strobe_cycle1", 32'(bus.mem_wr_enable), 1);
        @(negedge clk);
        check("wr_done_cycle2", 32'(bus.cl_done[2]), 1);
        check("wr_strobe_single", 32'(bus.mem_wr_enable), 0);
        bus.cl_request[2] = 1'b0;
        @(negedge clk);

        // Busy back-pressure on client 1 read of 0x0042, ready 3 cycles later
        t = '0;
        t.addr = 16'h0042; t.delay = 8'd3;
        model_push(1, t); rr_last = 1;
        raise(1, t);
        busy_until = cyc + 5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("busy_holds_rd", 32'(bus.mem_rd_enable), 0);
        end
        @(negedge clk);
        check("rd_after_busy", 32'(bus.mem_rd_enable), 1);
        wait_done(1, cycles);
        check("rd_done_latency", 32'(cycles), 4);

        // Read timeout on client 3
        t = '0;
        t.never = 1'b1; t.addr = 16'h0007;
        model_push(3, t); rr_last = 3;
        raise(3, t);
        wait_done(3, cycles);
        check("timeout_window", 32'(cycles >= RD_TIMEOUT + 1 && cycles <= RD_TIMEOUT + 3), 1);

        // All clients continuously requesting: strict rotation
        busy_rand = 1;
        for (int i = 0; i < CLIENTS; i++) cnt_b[i] = 3;
        run_batch();

        // Random batches
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < CLIENTS; i++) cnt_b[i] = $urandom_range(0, 3);
            cnt_b[$urandom_range(0, CLIENTS - 1)] = 1 + $urandom_range(0, 2);
            run_batch();
        end

        // Reset asserted while the read strobe is up
        busy_rand = 0;
        repeat (2) @(negedge clk);
        t = '0;
        t.never = 1'b1; t.addr = 16'h0003;
        model_push(1, t); rr_last = 1;
        raise(1, t);
        hit = 0;
        c0  = 0;
        while (!hit && c0 < 20) begin
            @(negedge clk);
            c0++;
            hit = bus.mem_rd_enable;
        end
        check("mid_read_strobe_seen", 32'(hit), 1);
        #1 nRst = 1'b0;
        #1;
        check("async_rst_rd_en", 32'(bus.mem_rd_enable), 0);
        check("async_rst_wr_en", 32'(bus.mem_wr_enable), 0);
        check("async_rst_done",  32'(bus.cl_done), 0);
        check("async_rst_error", 32'(bus.cl_error), 0);
        check("async_rst_grant", 32'(bus.grant_idx), 0);
        bus.cl_request = '0;
        exp_q.delete();
        plan_q.delete();
        rr_last = CLIENTS - 1;
        @(negedge clk);
        @(posedge clk);
        #2 nRst = 1'b1;

        // After reset: all request, client 0 must win first
        for (int i = 0; i < CLIENTS; i++) cnt_b[i] = 1;
        run_batch();
        busy_rand = 1;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < CLIENTS; i++) cnt_b[i] = $urandom_range(0, 2);
            cnt_b[$urandom_range(0, CLIENTS - 1)] = 2;
            run_batch();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
